// File: rtl/io_display_mmio.sv
// rtl/io_display_mmio.sv - IO-bus peripheral: N-digit 7-segment scanner, debounced switches, sticky change flag
module io_display_mmio #(
    parameter int NUM_DIGITS = 4,
    parameter int SEG_W      = 7,
    parameter int SCAN_BITS  = 16,
    parameter int SW_W       = 2,
    parameter int DEB_BITS   = 4
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [3:0]            IOAddr,
    input  logic [31:0]           IOWriteData,
    input  logic                  IOWriteEn,
    output logic [31:0]           IOReadData,
    input  logic [SW_W-1:0]       SW,
    output logic [SEG_W-1:0]      LED,
    output logic [NUM_DIGITS-1:0] AN
);
    localparam int DW    = NUM_DIGITS * SEG_W;
    localparam int CW    = NUM_DIGITS + 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [DW-1:0]         disp_q,  disp_d;
    logic [CW-1:0]         ctrl_q,  ctrl_d;
    logic [SCAN_BITS-1:0]  presc_q, presc_d;
    logic [IDX_W-1:0]      idx_q,   idx_d;
    logic [SW_W-1:0]       s1_q, s1_d, s2_q, s2_d;
    logic [SW_W-1:0]       cand_q, cand_d, stable_q, stable_d;
    logic [DEB_BITS-1:0]   cnt_q,   cnt_d;
    logic                  flag_q,  flag_d;
    logic [NUM_DIGITS-1:0] an_q,    an_d;
    logic [SEG_W-1:0]      led_q,   led_d;

    logic [SEG_W-1:0]      seg_sel;
    logic                  blank_sel;
    logic                  active;
    logic                  set_flag;
    logic                  unused_wdata;

    assign unused_wdata = ^IOWriteData;

    always_comb begin
        disp_d   = disp_q;
        ctrl_d   = ctrl_q;
        flag_d   = flag_q;
        presc_d  = presc_q + SCAN_BITS'(1);
        idx_d    = idx_q;
        s1_d     = SW;
        s2_d     = s1_q;
        cand_d   = cand_q;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        set_flag = 1'b0;
        seg_sel  = '0;
        blank_sel = 1'b0;
        an_d     = '1;

        if (IOWriteEn && IOAddr == 4'h0) disp_d = IOWriteData[DW-1:0];
        if (IOWriteEn && IOAddr == 4'h8) ctrl_d = IOWriteData[CW-1:0];

        if (presc_q == '1)
            idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);

        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                seg_sel   = disp_q[i*SEG_W +: SEG_W];
                blank_sel = ctrl_q[i+1];
            end
        end
        active = ctrl_q[0] && !blank_sel;
        for (int i = 0; i < NUM_DIGITS; i++)
            an_d[i] = !(active && idx_q == IDX_W'(i));
        led_d = active ? ~seg_sel : '1;

        // A new candidate restarts the count; it is accepted only after a full run of equal samples
        if (s2_q != cand_q) begin
            cand_d = s2_q;
            cnt_d  = '0;
        end else if (cand_q != stable_q) begin
            if (cnt_q == '1) begin
                stable_d = cand_q;
                set_flag = 1'b1;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + DEB_BITS'(1);
            end
        end else begin
            cnt_d = '0;
        end

        if (IOWriteEn && IOAddr == 4'hC) flag_d = 1'b0;
        if (set_flag) flag_d = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            disp_q   <= '0;
            ctrl_q   <= CW'(1);
            presc_q  <= '0;
            idx_q    <= '0;
            s1_q     <= '0;
            s2_q     <= '0;
            cand_q   <= '0;
            stable_q <= '0;
            cnt_q    <= '0;
            flag_q   <= 1'b0;
            an_q     <= '1;
            led_q    <= '1;
        end else begin
            disp_q   <= disp_d;
            ctrl_q   <= ctrl_d;
            presc_q  <= presc_d;
            idx_q    <= idx_d;
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            cand_q   <= cand_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            flag_q   <= flag_d;
            an_q     <= an_d;
            led_q    <= led_d;
        end
    end

    assign AN  = an_q;
    assign LED = led_q;

    always_comb begin
        IOReadData = '0;
        case (IOAddr)
            4'h0: IOReadData[DW-1:0]   = disp_q;
            4'h4: IOReadData[SW_W-1:0] = stable_q;
            4'h8: IOReadData[CW-1:0]   = ctrl_q;
            4'hC: begin
                IOReadData[0]          = flag_q;
                IOReadData[8 +: IDX_W] = idx_q;
            end
            default: IOReadData = '0;
        endcase
    end
endmodule
